// File: rtl/start_sequencer_if.sv
// Start sequencer signal bundle: track/button inputs and drive-stage outputs.
// master drives the inputs, slave is the sequencer itself.
interface start_sequencer_if;
   logic [1:0] circuit;
   logic       buton_start;
   logic       move;
   logic [1:0] run_circuit;
   logic [2:0] seconds_left;
   logic       go;
   logic       led_countdown;

   modport master (
      output circuit, buton_start,
      input  move, run_circuit, seconds_left, go, led_countdown
   );

   modport slave (
      input  circuit, buton_start,
      output move, run_circuit, seconds_left, go, led_countdown
   );
endinterface

// File: rtl/start_sequencer.sv
// Start sequencer: debounced start/stop button, track latch,
// COUNT_S-second countdown, then motion enable until the next press.
module start_sequencer #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int COUNT_S    = 5,
   parameter int DEB_CYCLES = 1_000_000
) (
   input logic            tact,
   input logic            rst_n,
   start_sequencer_if.slave bus
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [2:0]    S_INIT = 3'(COUNT_S);

   typedef enum logic [1:0] {
      IDLE,
      COUNTDOWN,
      RUN
   } state_t;

   logic [1:0]    circ_s1;
   logic [1:0]    circ_s2;
   logic          btn_s1;
   logic          btn_s2;
   logic [DW-1:0] deb_cnt;
   logic          deb_level;
   logic          deb_q;
   logic          press;
   logic          tick;
   logic          abort;
   logic [PW-1:0] presc;
   state_t        state;

   // button syncs reset to "released" so reset never fakes a press
   always_ff @(posedge tact or negedge rst_n) begin
      if (!rst_n) begin
         circ_s1 <= 2'b00;
         circ_s2 <= 2'b00;
         btn_s1  <= 1'b1;
         btn_s2  <= 1'b1;
      end else begin
         circ_s1 <= bus.circuit;
         circ_s2 <= circ_s1;
         btn_s1  <= bus.buton_start;
         btn_s2  <= btn_s1;
      end
   end

   always_ff @(posedge tact or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt   <= '0;
         deb_level <= 1'b1;
         deb_q     <= 1'b1;
      end else begin
         deb_q <= deb_level;
         if (btn_s2 == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == D_LAST) begin
            deb_level <= btn_s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   assign press = deb_q & ~deb_level;
   assign tick  = (presc == P_LAST);
   assign abort = press || (circ_s2 != bus.run_circuit);

   always_ff @(posedge tact or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         presc             <= '0;
         bus.move          <= 1'b0;
         bus.go            <= 1'b0;
         bus.run_circuit   <= 2'b00;
         bus.seconds_left  <= 3'd0;
         bus.led_countdown <= 1'b0;
      end else begin
         bus.go <= 1'b0;
         case (state)
            IDLE: begin
               if (press && circ_s2 != 2'b00) begin
                  state             <= COUNTDOWN;
                  bus.run_circuit   <= circ_s2;
                  bus.seconds_left  <= S_INIT;
                  presc             <= '0;
                  bus.led_countdown <= 1'b1;
               end
            end
            COUNTDOWN: begin
               // abort is tested first so it beats the final tick
               if (abort) begin
                  state             <= IDLE;
                  bus.seconds_left  <= 3'd0;
                  presc             <= '0;
                  bus.led_countdown <= 1'b0;
               end else if (tick) begin
                  presc <= '0;
                  if (bus.seconds_left == 3'd1) begin
                     state             <= RUN;
                     bus.seconds_left  <= 3'd0;
                     bus.move          <= 1'b1;
                     bus.go            <= 1'b1;
                     bus.led_countdown <= 1'b0;
                  end else begin
                     bus.seconds_left <= bus.seconds_left - 3'd1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            RUN: begin
               if (press) begin
                  state    <= IDLE;
                  bus.move <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: scenario tasks plus random stimulus,
// every cycle compared with a countdown-by-elapsed-time reference model.
module tb_start_sequencer;
   localparam int CLK_HZ  = 10;
   localparam int COUNT_S = 5;
   localparam int DEB     = 4;

   logic tact = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   start_sequencer_if bus();

   start_sequencer #(
      .CLK_HZ(CLK_HZ),
      .COUNT_S(COUNT_S),
      .DEB_CYCLES(DEB)
   ) dut (
      .tact(tact),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 tact = ~tact;

   // reference model: input histories, debounce run length, mode + elapsed
   bit [1:0] ch0, ch1;
   bit       bh0, bh1;
   int       run_len;
   bit       deb;
   bit       fell;
   int       mode;
   int       elapsed;
   bit       m_move, m_go, m_led;
   bit [1:0] m_rc;
   bit [2:0] m_sec;

   logic [7:0] obs;
   assign obs = {bus.move, bus.go, bus.run_circuit,
                 bus.seconds_left, bus.led_countdown};

   function automatic logic [7:0] exp_vec();
      return {m_move, m_go, m_rc, m_sec, m_led};
   endfunction

   task automatic model_reset();
      ch0 = 2'b00; ch1 = 2'b00;
      bh0 = 1'b1;  bh1 = 1'b1;
      run_len = 0; deb = 1'b1; fell = 1'b0;
      mode = 0; elapsed = 0;
      m_move = 0; m_go = 0; m_led = 0;
      m_rc = 2'b00; m_sec = 3'd0;
   endtask

   task automatic model_edge();
      bit       p;
      bit [1:0] c;
      bit       s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      p = fell;
      c = ch1;
      s = bh1;
      m_go = 0;
      case (mode)
         0: if (p && c != 2'b00) begin
            mode = 1; m_rc = c; elapsed = 0;
            m_sec = 3'(COUNT_S); m_led = 1;
         end
         1: if (p || c != m_rc) begin
            mode = 0; m_sec = 0; m_led = 0;
         end else begin
            elapsed++;
            if (elapsed == COUNT_S * CLK_HZ) begin
               mode = 2; m_sec = 0; m_move = 1;
               m_go = 1; m_led = 0;
            end else begin
               m_sec = 3'(COUNT_S - elapsed / CLK_HZ);
            end
         end
         default: if (p) begin
            mode = 0; m_move = 0;
         end
      endcase
      fell = 0;
      if (s == deb) begin
         run_len = 0;
      end else begin
         run_len++;
         if (run_len == DEB) begin
            deb = s; run_len = 0; fell = (s == 1'b0);
         end
      end
      ch1 = ch0; bh1 = bh0;
      ch0 = bus.circuit; bh0 = bus.buton_start;
   endtask

   task automatic step();
      @(posedge tact);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (bus.move !== 1'b0) begin
         bad++; $display("FAIL rst_move got=%b want=0", bus.move);
      end
      total++;
      if (bus.go !== 1'b0) begin
         bad++; $display("FAIL rst_go got=%b want=0", bus.go);
      end
      total++;
      if (bus.run_circuit !== 2'b00) begin
         bad++; $display("FAIL rst_rc got=%b want=00", bus.run_circuit);
      end
      total++;
      if (bus.seconds_left !== 3'd0) begin
         bad++; $display("FAIL rst_sec got=%0d want=0", bus.seconds_left);
      end
      total++;
      if (bus.led_countdown !== 1'b0) begin
         bad++; $display("FAIL rst_led got=%b want=0", bus.led_countdown);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL rst_idle cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_no_circuit();
      bus.circuit = 2'b00;
      for (int i = 0; i < 100; i++) begin
         bus.buton_start = (i < 20) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec() || obs !== 8'h00) begin
            bad++; $display("FAIL no_circuit cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_countdown();
      int entry = -1;
      int rise  = -1;
      int gos   = 0;
      bus.circuit = 2'b10;
      for (int i = 0; i < 90; i++) begin
         bus.buton_start = (i < 20) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL countdown cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.led_countdown === 1'b1 && entry < 0) entry = i;
         if (bus.move === 1'b1 && rise < 0) rise = i;
         if (bus.go === 1'b1) gos++;
      end
      total++;
      if (entry < 0 || rise - entry != COUNT_S * CLK_HZ) begin
         bad++; $display("FAIL cd_length got=%0d want=%0d", rise - entry, COUNT_S * CLK_HZ);
      end
      total++;
      if (gos != 1) begin
         bad++; $display("FAIL cd_go_count got=%0d want=1", gos);
      end
      total++;
      if (bus.run_circuit !== 2'b10) begin
         bad++; $display("FAIL cd_rc got=%b want=10", bus.run_circuit);
      end
   endtask

   task automatic test_run_stop();
      bus.circuit = 2'b01;
      for (int i = 0; i < 40; i++) begin
         bus.buton_start = (i >= 10 && i < 20) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL run_stop cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (i == 9) begin
            total++;
            if (bus.move !== 1'b1 || bus.run_circuit !== 2'b10) begin
               bad++; $display("FAIL run_circ_ignored got=%b/%b want=1/10", bus.move, bus.run_circuit);
            end
         end
      end
      total++;
      if (bus.move !== 1'b0 || bus.run_circuit !== 2'b10) begin
         bad++; $display("FAIL run_stopped got=%b/%b want=0/10", bus.move, bus.run_circuit);
      end
   endtask

   task automatic test_bounce();
      int rises = 0;
      bit prev  = 0;
      bus.circuit = 2'b01;
      for (int i = 0; i < 150; i++) begin
         if (i < 3)        bus.buton_start = 1'b0;
         else if (i < 6)   bus.buton_start = 1'b1;
         else if (i < 9)   bus.buton_start = 1'b0;
         else if (i < 11)  bus.buton_start = 1'b1;
         else if (i < 31)  bus.buton_start = 1'b0;
         else if (i < 100) bus.buton_start = 1'b1;
         else if (i < 103) bus.buton_start = 1'b0;
         else              bus.buton_start = 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL bounce cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.led_countdown === 1'b1 && !prev) rises++;
         prev = (bus.led_countdown === 1'b1);
      end
      total++;
      if (rises != 1) begin
         bad++; $display("FAIL bounce_entries got=%0d want=1", rises);
      end
      total++;
      if (bus.move !== 1'b1) begin
         bad++; $display("FAIL glitch_no_stop got=%b want=1", bus.move);
      end
      for (int i = 0; i < 20; i++) begin
         bus.buton_start = (i < 10) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL bounce_stop cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_abort_circuit();
      bit found = 0;
      bit moved = 0;
      bus.circuit = 2'b01;
      for (int i = 0; i < 100; i++) begin
         bus.buton_start = (i < 10) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL abort_c_wait cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.seconds_left === 3'd3) begin
            found = 1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL abort_c_reach got=timeout want=sec3");
      end
      bus.circuit = 2'b11;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL abort_c cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.move === 1'b1) moved = 1;
      end
      total++;
      if (moved || bus.seconds_left !== 3'd0 || bus.led_countdown !== 1'b0) begin
         bad++; $display("FAIL abort_c_end got=%b want=00010000", obs);
      end
   endtask

   task automatic test_abort_press();
      bit moved = 0;
      bus.circuit = 2'b01;
      for (int i = 0; i < 60; i++) begin
         bus.buton_start = (i < 10 || (i >= 30 && i < 40)) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL abort_p cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.move === 1'b1) moved = 1;
      end
      total++;
      if (moved || obs !== 8'b0001_0000) begin
         bad++; $display("FAIL abort_p_end got=%b want=00010000", obs);
      end
   endtask

   task automatic test_reset_run();
      int entry = -1;
      bus.circuit = 2'b10;
      for (int i = 0; i < 70; i++) begin
         bus.buton_start = (i < 10) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL rr_setup cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
      end
      total++;
      if (bus.move !== 1'b1) begin
         bad++; $display("FAIL rr_running got=%b want=1", bus.move);
      end
      bus.buton_start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 8'h00) begin
         bad++; $display("FAIL rr_async got=%b want=00000000", obs);
      end
      model_reset();
      for (int i = 0; i < 4; i++) step();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL rr_held cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
         if (bus.led_countdown === 1'b1 && entry < 0) entry = i;
      end
      total++;
      if (entry != 2 + DEB) begin
         bad++; $display("FAIL rr_entry got=%0d want=%0d", entry, 2 + DEB);
      end
      for (int i = 0; i < 30; i++) begin
         bus.buton_start = (i >= 10 && i < 20) ? 1'b0 : 1'b1;
         step();
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL rr_clean cyc=%0d got=%b want=%b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int len;
      for (int seg = 0; seg < 120; seg++) begin
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90)
                                           : $urandom_range(1, 8);
         bus.buton_start = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) bus.circuit = 2'($urandom_range(0, 3));
         for (int i = 0; i < len; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
               bad++; $display("FAIL random seg=%0d cyc=%0d got=%b want=%b", seg, i, obs, exp_vec());
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.circuit = 2'b00;
      bus.buton_start = 1'b1;
      model_reset();
      test_reset();
      test_no_circuit();
      test_countdown();
      test_run_stop();
      test_bounce();
      test_abort_circuit();
      test_abort_press();
      test_reset_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
